// File: rtl/fpadd_arb_pkg.sv
// Shared types and constants for the fpadd arbiter: FSM encoding, quiet-NaN
// result for aborted operations, and the default watchdog limit.
package fpadd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
    localparam int          DEFAULT_TIMEOUT = 15;
    localparam int          WD_W            = 4;

endpackage

// File: rtl/fpadd_arbiter_rr_select.sv
// Combinational round-robin picker: rotate the request vector by the pointer,
// take the lowest set bit, then map the offset back to a requester index.
module rr_select
    import fpadd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   winner_o,
    output logic            valid_o
);

    logic [2*NREQ-1:0] reqTwice;
    logic [NREQ-1:0]   rotated;
    logic [PW-1:0]     offset;
    logic [PW:0]       sum;

    // Duplicating the vector turns the rotate into a plain shift, valid because
    // the pointer never exceeds NREQ-1.
    always_comb begin
        reqTwice = {req_i, req_i} >> ptr_i;
        rotated  = reqTwice[NREQ-1:0];
        offset   = '0;
        valid_o  = |rotated;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = PW'(k);
            end
        end
        sum = {1'b0, offset} + {1'b0, ptr_i};
        if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
        end
        winner_o = sum[PW-1:0];
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpadd unit between NREQ
// requesters, with a watchdog that aborts a stalled operation with a quiet NaN.
module fpadd_arbiter
    import fpadd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] dataa_in,
    input  logic [32*NREQ-1:0] datab_in,
    output logic [NREQ-1:0]    ack,
    output logic [31:0]        result,
    output logic               busy,
    output logic               err,
    output logic               fp_start,
    output logic [31:0]        fp_dataa,
    output logic [31:0]        fp_datab,
    input  logic [31:0]        fp_result,
    input  logic               fp_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q;
    logic [PW-1:0]   grant_q;
    logic [PW-1:0]   ptr_q;
    logic [WD_W-1:0] wd_q;
    logic [NREQ-1:0] ack_q;
    logic [31:0]     result_q;
    logic            busy_q;
    logic            err_q;
    logic            fpStart_q;
    logic [31:0]     fpDataA_q;
    logic [31:0]     fpDataB_q;

    logic [PW-1:0]   winner_d;
    logic            winValid_d;
    logic [31:0]     opA_d;
    logic [31:0]     opB_d;
    logic [NREQ-1:0] ackSet_d;

    rr_select #(
        .NREQ (NREQ),
        .PW   (PW)
    ) uSelect (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner_d),
        .valid_o  (winValid_d)
    );

    always_comb begin
        opA_d = '0;
        opB_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_d == PW'(i)) begin
                opA_d = dataa_in[32*i +: 32];
                opB_d = datab_in[32*i +: 32];
            end
        end
        ackSet_d = NREQ'(1) << grant_q;
    end

    // Operands stay frozen from IDLE until the next grant, so fpadd sees stable
    // inputs for the whole operation even if the requester lets go of req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            ack_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            fpStart_q <= 1'b0;
            fpDataA_q <= '0;
            fpDataB_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (winValid_d) begin
                        grant_q   <= winner_d;
                        fpDataA_q <= opA_d;
                        fpDataB_q <= opB_d;
                        fpStart_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    fpStart_q <= 1'b0;
                    wd_q      <= '0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (fp_done) begin
                        result_q <= fp_result;
                        ack_q    <= ackSet_d;
                        state_q  <= ST_RESP;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        result_q <= FP_QNAN;
                        ack_q    <= ackSet_d;
                        err_q    <= 1'b1;
                        state_q  <= ST_RESP;
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    ack_q   <= '0;
                    ptr_q   <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign fp_start = fpStart_q;
    assign fp_dataa = fpDataA_q;
    assign fp_datab = fpDataB_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural fpadd stand-in whose
// latency, returned sum and stuck-done behaviour are set per step.
module tb_fpadd_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] dataa_in = '0;
    logic [127:0] datab_in = '0;
    logic [3:0]   ack;
    logic [31:0]  result;
    logic         busy;
    logic         err;
    logic         fp_start;
    logic [31:0]  fp_dataa;
    logic [31:0]  fp_datab;
    logic [31:0]  fp_result = '0;
    logic         fp_done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic        stubStuck = 1'b0;
    int          stubLatency = 3;
    int          stubCnt = 0;
    logic [31:0] stubSum = '0;
    logic [31:0] stubA = '0;

    fpadd_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dataa_in  (dataa_in),
        .datab_in  (datab_in),
        .ack       (ack),
        .result    (result),
        .busy      (busy),
        .err       (err),
        .fp_start  (fp_start),
        .fp_dataa  (fp_dataa),
        .fp_datab  (fp_datab),
        .fp_result (fp_result),
        .fp_done   (fp_done)
    );

    always #5 clk = ~clk;

    // fpadd stand-in: the start pulse loads operands and clears done; done then
    // rises so that it is first visible stubLatency cycles after LOAD began.
    always @(posedge clk) begin
        if (fp_start) begin
            fp_done <= 1'b0;
            stubCnt <= stubLatency - 1;
            stubA   <= fp_dataa;
        end else if (stubCnt > 1) begin
            stubCnt <= stubCnt - 1;
        end else if (stubCnt == 1) begin
            stubCnt <= 0;
            if (!stubStuck) begin
                fp_done   <= 1'b1;
                fp_result <= stubSum;
            end
        end
    end

    function automatic logic [31:0] opA(input int k);
        return 32'h3000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] opB(input int k);
        return 32'h0600_0000 + 32'(k);
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic waitAck(input int budget, output int cycles);
        cycles = 0;
        while (ack === 4'b0000 && cycles < budget) begin
            stepCycle();
            cycles++;
        end
    endtask

    // One isolated request from a single requester, checked through LOAD,
    // the ack cycle and the return to IDLE.
    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] stubVal, input logic [31:0] expRes,
                                 input int lat, input int expWait, input bit dropEarly,
                                 input string tag);
        int waited;
        stubSum     = stubVal;
        stubLatency = lat;
        dataa_in[32*idx +: 32] = a;
        datab_in[32*idx +: 32] = b;
        req[idx] = 1'b1;
        stepCycle();
        checkOutput({tag, " loadStart"}, 32'(fp_start), 32'd1);
        checkOutput({tag, " loadBusy"}, 32'(busy), 32'd1);
        checkOutput({tag, " loadA"}, fp_dataa, a);
        checkOutput({tag, " loadB"}, fp_datab, b);
        stepCycle();
        checkOutput({tag, " startClear"}, 32'(fp_start), 32'd0);
        if (dropEarly) req[idx] = 1'b0;
        waitAck(30, waited);
        checkOutput({tag, " wait"}, 32'(waited), 32'(expWait));
        checkOutput({tag, " ack"}, 32'(ack), 32'd1 << idx);
        checkOutput({tag, " result"}, result, expRes);
        checkOutput({tag, " frozenA"}, fp_dataa, a);
        checkOutput({tag, " respBusy"}, 32'(busy), 32'd1);
        req[idx] = 1'b0;
        stepCycle();
        checkOutput({tag, " ackClear"}, 32'(ack), 32'd0);
        checkOutput({tag, " idleBusy"}, 32'(busy), 32'd0);
    endtask

    // Waits for the next ack from a contended set and retires that requester.
    task automatic serveOne(input int k, input string tag);
        int waited;
        waitAck(20, waited);
        checkOutput({tag, " ack"}, 32'(ack), 32'd1 << k);
        checkOutput({tag, " result"}, result, stubSum);
        checkOutput({tag, " opA"}, stubA, opA(k));
        req[k] = 1'b0;
        stepCycle();
        checkOutput({tag, " ackClear"}, 32'(ack), 32'd0);
    endtask

    initial begin
        bit sawAck;
        $display("[TB] fpadd_arbiter directed run");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst ack", 32'(ack), 32'd0);
        checkOutput("rst result", result, 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst err", 32'(err), 32'd0);
        checkOutput("rst fpStart", 32'(fp_start), 32'd0);
        checkOutput("rst fpA", fp_dataa, 32'd0);
        checkOutput("rst fpB", fp_datab, 32'd0);
        reset = 1'b0;
        stepCycle();

        applyStimulus(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000,
                      3, 3, 1'b0, "single");
        applyStimulus(1, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, 32'h0000_0000,
                      4, 4, 1'b0, "cancel");
        applyStimulus(2, 32'h4120_0000, 32'h3F80_0000, 32'h4130_0000, 32'h4130_0000,
                      5, 5, 1'b1, "lateDrop");

        // Pointer sits at 3 after the late-drop grant, so 3 must beat 0.
        for (int i = 0; i < 4; i++) begin
            dataa_in[32*i +: 32] = opA(i);
            datab_in[32*i +: 32] = opB(i);
        end
        stubSum     = 32'h4080_0000;
        stubLatency = 4;
        req = 4'b1001;
        serveOne(3, "probe3");
        serveOne(0, "probe0");

        stubLatency = 7;
        req = 4'b0001;
        repeat (4) stepCycle();
        checkOutput("midRun busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRst ack", 32'(ack), 32'd0);
        checkOutput("asyncRst result", result, 32'd0);
        checkOutput("asyncRst busy", 32'(busy), 32'd0);
        checkOutput("asyncRst fpStart", 32'(fp_start), 32'd0);
        checkOutput("asyncRst fpA", fp_dataa, 32'd0);
        checkOutput("asyncRst fpB", fp_datab, 32'd0);
        req = 4'b0000;
        #1 reset = 1'b0;
        sawAck = 1'b0;
        repeat (10) begin
            stepCycle();
            if (ack !== 4'b0000 || busy !== 1'b0) sawAck = 1'b1;
        end
        checkOutput("postRst noAck", 32'(sawAck), 32'd0);

        stubSum     = 32'h4100_0000;
        stubLatency = 4;
        req = 4'b1111;
        serveOne(0, "rr0");
        serveOne(1, "rr1");
        serveOne(2, "rr2");
        serveOne(3, "rr3");
        req = 4'b1001;
        serveOne(0, "pair0");
        serveOne(3, "pair3");
        checkOutput("preTimeout err", 32'(err), 32'd0);

        stubStuck = 1'b1;
        applyStimulus(1, 32'h3F80_0000, 32'h3F80_0000, 32'h1234_5678, 32'h7FC0_0000,
                      3, 16, 1'b0, "timeout");
        checkOutput("timeout err", 32'(err), 32'd1);
        stubStuck = 1'b0;
        applyStimulus(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000,
                      5, 5, 1'b0, "afterTimeout");
        checkOutput("sticky err", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Shares one multi-cycle `fpadd` unit between `NREQ` requesters, for example the voice mixers and envelope accumulators in the DSP path. The arbiter grants requesters in round-robin order and latches the winner's operands. It starts `fpadd` by pulsing fpadd's `reset` input, which is also that unit's load strobe. It waits for `done`, then returns the sum to the winner with a one-cycle `ack`. A watchdog bounds each operation so that a stalled adder cannot hang the requesters.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 15: maximum number of RUN cycles before the operation is aborted.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  level request per requester. Operands must be held stable while `req` is high.
- `dataa_in`  in  32*NREQ  operand A. Requester i uses bits [32i+31:32i].
- `datab_in`  in  32*NREQ  operand B, same packing as `dataa_in`.
- `ack`  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- `result`  out  32  sum; valid only while `ack` is nonzero.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky; set on a watchdog timeout, cleared only by `reset`.
- `fp_start`  out  1  connects to fpadd `reset`.
- `fp_dataa`  out  32  connects to fpadd `dataa`.
- `fp_datab`  out  32  connects to fpadd `datab`.
- `fp_result`  in  32  connects to fpadd `result`.
- `fp_done`  in  1  connects to fpadd `done`.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `result`=0, `busy`=0, `err`=0, `fp_start`=0, `fp_dataa`=0, `fp_datab`=0, round-robin pointer=0, state=IDLE, watchdog=0.
- FSM state IDLE:
  - If `req` is nonzero, `rr_select` picks the first set bit at or above the pointer, wrapping around.
  - Register `grant` ← winner, `fp_dataa`/`fp_datab` ← winner's operands, and `fp_start` ← 1. Go to LOAD.
  - If `req` is zero, stay in IDLE.
- FSM state LOAD: `fp_start` is high for exactly this one cycle, so fpadd samples its operands and clears `done` at the end of LOAD. Clear `fp_start`, clear the watchdog, go to RUN.
- FSM state RUN:
  - `fp_dataa`/`fp_datab` stay frozen.
  - If `fp_done`=1: `result` ← `fp_result`, `ack[grant]` ← 1, go to RESP.
  - Otherwise, if the watchdog equals `TIMEOUT`: `result` ← 32'h7FC0_0000 (quiet NaN), `ack[grant]` ← 1, `err` ← 1, go to RESP.
  - Otherwise increment the watchdog. The watchdog is 4 bits wide and saturates; it never wraps.
- FSM state RESP: `ack` is high for this one cycle. Clear `ack`, set the pointer ← `grant`+1 modulo `NREQ`, go to IDLE.
- Requester protocol:
  - On seeing `ack`, a requester deasserts `req` on the clock edge that ends RESP. The arbiter therefore samples `req` low in the following IDLE cycle.
  - A `req` still high in that IDLE cycle is a new request.
- If `req` drops during LOAD or RUN, the operation still completes and `ack` is still pulsed. No cancel path exists.
- Asserting `reset` during LOAD or RUN aborts the operation immediately with no `ack`. fpadd is left mid-computation; the next LOAD restarts it cleanly.
- `req` bits above `NREQ-1` do not exist. The pointer never exceeds `NREQ-1`.

## Timing
- A request first seen in IDLE at cycle 0 produces: LOAD at cycle 1, RUN from cycle 2, and `ack` in the cycle after `fp_done` is sampled.
- With fpadd's 3–7 cycle latency, the total from request to `ack` is 5–9 cycles.
- Back-to-back throughput is one operation per (latency + 3) cycles. IDLE, LOAD and RESP each take one cycle.
- A timeout produces `ack` at cycle 3+`TIMEOUT`.
- Only one operation is in flight at a time; fpadd is not pipelined.

## Structure
- Package `fpadd_arb_pkg` holds:
  - the state encoding (IDLE=0, LOAD=1, RUN=2, RESP=3);
  - `FP_QNAN` = 32'h7FC0_0000;
  - the default `TIMEOUT` value.
- Sub-module `rr_select` is combinational. Inputs are `req[NREQ-1:0]` and the pointer; outputs are the winner index and a valid flag. It rotates the request vector by the pointer, then does a lowest-bit-first priority encode.
- The fpadd instance lives in the parent module, not inside this block.

## Test plan
- Single request, real fpadd: req0 with A=0x3F800000 (1.0), B=0x40000000 (2.0) → `fp_start` high for exactly one cycle, then `ack`=0001 with `result`=0x40400000 (3.0). `busy` is high from LOAD through RESP.
- Cancellation: req1 with A=0x3FC00000, B=0xBFC00000 → `ack`=0010, `result`=0x00000000.
- Contention: req=1111 held, with each requester dropping its `req` after its `ack` → acks occur in the order 0001, 0010, 0100, 1000. Then req=1001 with pointer=0 → 0001 first, then 1000.
- Timeout: stub fpadd with `fp_done` tied to 0 → `ack` at cycle 3+`TIMEOUT` with `result`=0x7FC00000, `err`=1. `err` stays 1 through a later successful operation.
- Reset mid-RUN: assert `reset` two cycles into RUN → all outputs return to zero asynchronously and no `ack` is issued. The next request completes correctly.
- Late drop: req2 is deasserted during RUN → `ack`=0100 still pulses and the pointer advances to 3.
